multicycle_controller: RTL and testbench

- Sequenced successor to the single-cycle decoder: a finite-state controller for the multi-cycle CPU datapath.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Requests instruction and data memory through req/ack handshakes with a parametrised wait timeout.
- Issues one-cycle write strobes, counts retired instructions, and traps undefined opcodes into a sticky error state.

---
 rtl/multicycle_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Finite-state controller for a multi-cycle CPU datapath. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. Instruction and
// data memory are driven through req/ack handshakes guarded by a wait
// timeout. Undefined opcodes and expired waits park the controller in a
// sticky ERR state that only cpu_rst can leave.
//
// Parameters:
//   TIMEOUT  cycles a request may wait for ack before ERR (0 = never)
//   CNT_W    width of the retired-instruction counter
// Ports:
//   cpu_clk   in   clock, rising edge
//   cpu_rst   in   asynchronous active-high reset
//   run       in   permission to start a new fetch
//   inst      in   IR contents (opcode [31:26], funct3 [24:22])
//   irom_req  out  instruction fetch request
//   irom_ack  in   instruction word valid
//   dram_req  out  data memory request
//   dram_ack  in   data memory done / read data valid
//   ram_we    out  store qualifier, meaningful while dram_req=1
//   ir_we     out  latch fetched word into IR
//   pc_we     out  commit next PC (one pulse per instruction)
//   rf_we     out  register-file write strobe
//   state     out  current state code
//   err       out  sticky error flag
//   instret   out  retired-instruction count (wraps)
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int          CNT_W   = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             run,
    input  logic [31:0]      inst,
    output logic             irom_req,
    input  logic             irom_ack,
    output logic             dram_req,
    input  logic             dram_ack,
    output logic             ram_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU       = 3'd0,
        C_LU12I     = 3'd1,
        C_PCADDU12I = 3'd2,
        C_LS        = 3'd3,
        C_BR        = 3'd4,
        C_LINK      = 3'd5,
        C_ILL       = 3'd6
    } class_t;

    // Counter is wide enough to hold TIMEOUT itself.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    function automatic class_t classify(input logic [5:0] op);
        class_t c;
        case (op)
            6'b000000: c = C_ALU;
            6'b000101: c = C_LU12I;
            6'b000111: c = C_PCADDU12I;
            6'b001010: c = C_LS;
            6'b010110, 6'b010111, 6'b011000, 6'b011001,
            6'b011010, 6'b011011, 6'b010100: c = C_BR;
            6'b010011, 6'b010101: c = C_LINK;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t            state_r;
    class_t            cls_r;
    logic              store_r;
    logic              fetch_pend_r;   // irom_req raised and not yet acked
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  instret_r;

    class_t dec_cls_s;
    logic   timeout_s;
    logic   irom_req_s, dram_req_s, ram_we_s, ir_we_s, pc_we_s, rf_we_s;
    logic   unused_s;

    assign dec_cls_s = classify(inst[31:26]);
    assign unused_s  = ^{inst[25], inst[23:0]};

    // Ack in the same cycle still wins: callers test ack before timeout_s.
    assign timeout_s = (TIMEOUT != 32'd0) &&
                       ((32'(wait_cnt_r) + 32'd1) == TIMEOUT);

    // Output decode; gated by cpu_rst so everything falls without a clock edge.
    always_comb begin
        irom_req_s = 1'b0;
        dram_req_s = 1'b0;
        ram_we_s   = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        rf_we_s    = 1'b0;
        if (cpu_rst) begin
            irom_req_s = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    irom_req_s = run | fetch_pend_r;
                    ir_we_s    = (run | fetch_pend_r) & irom_ack;
                end
                S_EXEC: begin
                    pc_we_s = (cls_r == C_BR);
                end
                S_MEM: begin
                    dram_req_s = 1'b1;
                    ram_we_s   = store_r;
                    pc_we_s    = store_r & dram_ack;
                end
                S_WB: begin
                    rf_we_s = 1'b1;
                    pc_we_s = 1'b1;
                end
                default: begin
                    irom_req_s = 1'b0;
                end
            endcase
        end
    end

    // Controller state, instruction class, wait counter and retire counter.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_r      <= S_FETCH;
            cls_r        <= C_ALU;
            store_r      <= 1'b0;
            fetch_pend_r <= 1'b0;
            wait_cnt_r   <= '0;
            instret_r    <= '0;
        end else begin
            // Retirement lands one cycle after the pc_we pulse.
            if (pc_we_s) begin
                instret_r <= instret_r + CNT_ONE;
            end else begin
                instret_r <= instret_r;
            end

            case (state_r)
                S_FETCH: begin
                    if (irom_req_s && irom_ack) begin
                        state_r      <= S_DECODE;
                        fetch_pend_r <= 1'b0;
                        wait_cnt_r   <= '0;
                    end else if (irom_req_s && timeout_s) begin
                        state_r      <= S_ERR;
                        fetch_pend_r <= 1'b0;
                    end else if (irom_req_s) begin
                        fetch_pend_r <= 1'b1;
                        wait_cnt_r   <= wait_cnt_r + WAIT_ONE;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    cls_r   <= dec_cls_s;
                    store_r <= inst[24];
                    state_r <= (dec_cls_s == C_ILL) ? S_ERR : S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt_r <= '0;
                    if (cls_r == C_BR) begin
                        state_r <= S_FETCH;
                    end else if (cls_r == C_LS) begin
                        state_r <= S_MEM;
                    end else begin
                        state_r <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dram_ack) begin
                        state_r    <= store_r ? S_FETCH : S_WB;
                        wait_cnt_r <= '0;
                    end else if (timeout_s) begin
                        state_r <= S_ERR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                S_WB: begin
                    state_r    <= S_FETCH;
                    wait_cnt_r <= '0;
                end
                S_ERR: begin
                    state_r <= S_ERR;
                end
                default: begin
                    // Unreachable codes 5/6 recover to a clean fetch.
                    state_r      <= S_FETCH;
                    fetch_pend_r <= 1'b0;
                    wait_cnt_r   <= '0;
                end
            endcase
        end
    end

    assign irom_req = irom_req_s;
    assign dram_req = dram_req_s;
    assign ram_we   = ram_we_s;
    assign ir_we    = ir_we_s;
    assign pc_we    = pc_we_s;
    assign rf_we    = rf_we_s;
    assign state    = state_r;
    assign err      = (state_r == S_ERR);
    assign instret  = instret_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (TIMEOUT=4, CNT_W=4).
// Expected control vectors and retire counts are queued when stimulus is
// driven and popped/compared when the outputs are sampled mid-cycle.
module tb_multicycle_controller;

    localparam int unsigned TIMEOUT = 4;
    localparam int          CNT_W   = 4;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                           ST_M = 3'd3, ST_W = 3'd4, ST_X = 3'd7;
    // {irom_req, ir_we, dram_req, ram_we, pc_we, rf_we, err}
    localparam logic [6:0] NONE = 7'b0000000, FREQ = 7'b1000000,
                           FACK = 7'b1100000, MREQ = 7'b0010000,
                           MST  = 7'b0011000, MSTA = 7'b0011100,
                           BRX  = 7'b0000100, WBS  = 7'b0000110,
                           ERRS = 7'b0000001;

    localparam logic [31:0] I_ALU = 32'h0010_0000, I_LOAD = 32'h2880_0000,
                            I_STORE = 32'h2980_0000, I_ILL = 32'hFC00_0000,
                            I_BR = 32'h5800_0000;

    logic cpu_clk = 1'b0;
    logic cpu_rst, run, irom_ack, dram_ack;
    logic [31:0] inst;
    logic irom_req, dram_req, ram_we, ir_we, pc_we, rf_we, err;
    logic [2:0] state;
    logic [CNT_W-1:0] instret;

    typedef struct {
        string      tag;
        logic       is_cnt;
        logic [9:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  exp_ret = 0;

    always #5 cpu_clk = ~cpu_clk;

    multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .run(run), .inst(inst),
        .irom_req(irom_req), .irom_ack(irom_ack), .dram_req(dram_req),
        .dram_ack(dram_ack), .ram_we(ram_we), .ir_we(ir_we), .pc_we(pc_we),
        .rf_we(rf_we), .state(state), .err(err), .instret(instret)
    );

    task automatic expect_ctl(input string tag, input logic [2:0] st,
                              input logic [6:0] strobes);
        sb_t e;
        e.tag = tag; e.is_cnt = 1'b0; e.exp = {st, strobes};
        sb_q.push_back(e);
    endtask

    task automatic expect_cnt(input string tag);
        sb_t e;
        e.tag = tag; e.is_cnt = 1'b1; e.exp = 10'(exp_ret % 16);
        sb_q.push_back(e);
    endtask

    task automatic check_all();
        sb_t e;
        logic [9:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = e.is_cnt ? 10'(instret)
                           : {state, irom_req, ir_we, dram_req, ram_we, pc_we, rf_we, err};
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Inputs change at posedge+1, outputs are checked at posedge+4.
    task automatic cyc();
        #3;
        check_all();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic retire();
        exp_ret = (exp_ret + 1) % 16;
    endtask

    initial begin
        cpu_rst = 1'b1; run = 1'b0; irom_ack = 1'b0; dram_ack = 1'b0; inst = I_ALU;
        @(posedge cpu_clk); #1;

        // Held in reset with requests and acks toggling: everything quiet.
        run = 1'b1; irom_ack = 1'b1; dram_ack = 1'b1;
        expect_ctl("reset_ctl", ST_F, NONE); expect_cnt("reset_cnt"); cyc();
        cpu_rst = 1'b0; dram_ack = 1'b0;

        // ALU with immediate ack: 0,1,2,4,0.
        expect_ctl("alu_fetch", ST_F, FACK); cyc();
        expect_ctl("alu_dec", ST_D, NONE); cyc();
        expect_ctl("alu_exec", ST_E, NONE); cyc();
        expect_ctl("alu_wb", ST_W, WBS); expect_cnt("alu_cnt_pre"); cyc(); retire();
        run = 1'b0;   // irom_ack still 1 but no request: must be ignored
        expect_ctl("alu_idle", ST_F, NONE); expect_cnt("alu_cnt"); cyc();

        // Load, dram_ack after 3 waiting cycles (acks as the count hits TIMEOUT).
        run = 1'b1; irom_ack = 1'b1; inst = I_LOAD;
        expect_ctl("ld_fetch", ST_F, FACK); cyc();
        run = 1'b0; irom_ack = 1'b0;
        expect_ctl("ld_dec", ST_D, NONE); cyc();
        expect_ctl("ld_exec", ST_E, NONE); cyc();
        for (int i = 0; i < 3; i++) begin
            expect_ctl("ld_mem_wait", ST_M, MREQ); cyc();
        end
        dram_ack = 1'b1;
        expect_ctl("ld_mem_ack", ST_M, MREQ); cyc();
        dram_ack = 1'b0;
        expect_ctl("ld_wb", ST_W, WBS); cyc(); retire();
        expect_ctl("ld_idle", ST_F, NONE); expect_cnt("ld_cnt"); cyc();

        // Store, one waiting cycle then ack.
        run = 1'b1; irom_ack = 1'b1; inst = I_STORE;
        expect_ctl("st_fetch", ST_F, FACK); cyc();
        run = 1'b0; irom_ack = 1'b0;
        expect_ctl("st_dec", ST_D, NONE); cyc();
        expect_ctl("st_exec", ST_E, NONE); cyc();
        expect_ctl("st_mem_wait", ST_M, MST); cyc();
        dram_ack = 1'b1;
        expect_ctl("st_mem_ack", ST_M, MSTA); cyc(); retire();
        dram_ack = 1'b0;
        expect_ctl("st_idle", ST_F, NONE); expect_cnt("st_cnt"); cyc();

        // Fetch request stays up after run drops.
        run = 1'b1; inst = I_BR;
        expect_ctl("hold_req", ST_F, FREQ); cyc();
        run = 1'b0;
        expect_ctl("hold_norun", ST_F, FREQ); cyc();
        irom_ack = 1'b1;
        expect_ctl("hold_ack", ST_F, FACK); cyc();
        irom_ack = 1'b0;
        expect_ctl("hold_dec", ST_D, NONE); cyc();
        expect_ctl("hold_br", ST_E, BRX); cyc(); retire();
        expect_ctl("hold_idle", ST_F, NONE); expect_cnt("hold_cnt"); cyc();

        // irom_ack on exactly the 4th waiting cycle: success.
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_ctl("to4_wait", ST_F, FREQ); cyc();
        end
        irom_ack = 1'b1;
        expect_ctl("to4_ack", ST_F, FACK); cyc();
        run = 1'b0; irom_ack = 1'b0;
        expect_ctl("to4_dec", ST_D, NONE); cyc();
        expect_ctl("to4_br", ST_E, BRX); cyc(); retire();
        expect_ctl("to4_idle", ST_F, NONE); expect_cnt("to4_cnt"); cyc();

        // Illegal opcode traps; ERR ignores run and both acks.
        run = 1'b1; irom_ack = 1'b1; inst = I_ILL;
        expect_ctl("ill_fetch", ST_F, FACK); cyc();
        expect_ctl("ill_dec", ST_D, NONE); cyc();
        dram_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            expect_ctl("ill_err", ST_X, ERRS); expect_cnt("ill_cnt_frozen"); cyc();
        end
        cpu_rst = 1'b1; exp_ret = 0;
        #1;
        expect_ctl("ill_rst", ST_F, NONE); expect_cnt("ill_rst_cnt"); check_all();
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0; run = 1'b0; irom_ack = 1'b0; dram_ack = 1'b0;

        // irom_ack never arrives: ERR after 4 waiting cycles.
        run = 1'b1; inst = I_BR;
        for (int i = 0; i < 4; i++) begin
            expect_ctl("tmo_wait", ST_F, FREQ); cyc();
        end
        expect_ctl("tmo_err", ST_X, ERRS); cyc();
        cpu_rst = 1'b1;
        #1;
        expect_ctl("tmo_rst", ST_F, NONE); check_all();
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;

        // 16 branches: the counter climbs to 15 then wraps to 0.
        irom_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_cnt("wrap_cnt");
            expect_ctl("wrap_fetch", ST_F, FACK); cyc();
            expect_ctl("wrap_dec", ST_D, NONE); cyc();
            expect_ctl("wrap_br", ST_E, BRX); cyc(); retire();
        end
        run = 1'b0; irom_ack = 1'b0;
        expect_ctl("wrap_idle", ST_F, NONE); expect_cnt("wrap_zero"); cyc();

        // Asynchronous reset in the middle of MEM drops dram_req at once.
        run = 1'b1; irom_ack = 1'b1; inst = I_LOAD;
        expect_ctl("mr_fetch", ST_F, FACK); cyc();
        run = 1'b0; irom_ack = 1'b0;
        expect_ctl("mr_dec", ST_D, NONE); cyc();
        expect_ctl("mr_exec", ST_E, NONE); cyc();
        expect_ctl("mr_mem", ST_M, MREQ);
        #3; check_all();
        cpu_rst = 1'b1; exp_ret = 0;
        #1;
        expect_ctl("mr_rst", ST_F, NONE); expect_cnt("mr_rst_cnt"); check_all();
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        expect_ctl("mr_idle", ST_F, NONE); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
